// File: rtl/instruction_memory_loader.sv
// instruction_memory_loader
//   Instruction store with a boot/program loader in front of it. A
//   valid/ready stream fills a contiguous word range under a small FSM.
//   The fetch port has a registered read with a valid flag and an
//   out-of-range fault. Fetch is stalled while a load is in progress.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   ld_start        : begin a load (sampled only in IDLE)
//   ld_base         : first word address of the load
//   ld_count        : number of words to load (0 = empty load)
//   ld_valid        : ld_data carries a word this cycle
//   ld_data         : word to write
//   ld_ready        : loader accepts ld_data (high for all of LOAD)
//   ld_busy         : loader FSM in LOAD
//   ld_done         : one-cycle pulse when a load completes
//   ld_overflow     : sticky, a word of the current/last load was dropped
//   fetch_req       : fetch request
//   fetch_addr      : word address to fetch
//   fetch_data      : registered instruction word
//   fetch_valid     : fetch_data/fetch_fault valid this cycle
//   fetch_fault     : registered fetch was out of range
//   stall           : fetch port unavailable (equals ld_busy)
module instruction_memory_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 1024,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_start,
  input  logic [ADDR_WIDTH-1:0] ld_base,
  input  logic [ADDR_WIDTH-1:0] ld_count,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  ld_busy,
  output logic                  ld_done,
  output logic                  ld_overflow,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_valid,
  output logic                  fetch_fault,
  output logic                  stall
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // One extra bit so a pointer that runs off the top of the address space
  // stays out of range instead of wrapping back onto low memory.
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_remaining;
  logic                  r_overflow;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic w_beat;
  logic w_wr_in_range;
  logic w_wr_en;
  logic w_fetch_in_range;

  assign w_beat           = (r_state == S_LOAD) && ld_valid;
  assign w_wr_in_range    = (r_wr_ptr >> IDX_W) == '0;
  assign w_fetch_in_range = (fetch_addr >> IDX_W) == '0;
  // The beat presented while rst is high must not reach the memory.
  assign w_wr_en          = w_beat && w_wr_in_range && !rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (ld_start) begin
          w_state_next = (ld_count != '0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        if (ld_valid && (r_remaining == ADDR_WIDTH'(1))) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    ld_ready = 1'b0;
    ld_busy  = 1'b0;
    ld_done  = 1'b0;
    case (r_state)
      S_LOAD: begin
        ld_ready = 1'b1;
        ld_busy  = 1'b1;
      end
      S_DONE:  ld_done = 1'b1;
      default: ;
    endcase
  end

  assign stall       = ld_busy;
  assign ld_overflow = r_overflow;

  // Loader datapath: write pointer, beat counter, sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_remaining <= '0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ld_start) begin
            r_wr_ptr    <= {1'b0, ld_base};
            r_remaining <= ld_count;
            r_overflow  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            r_wr_ptr    <= r_wr_ptr + (ADDR_WIDTH+1)'(1);
            r_remaining <= r_remaining - ADDR_WIDTH'(1);
            if (!w_wr_in_range) begin
              r_overflow <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[IDX_W-1:0]] <= ld_data;
    end
  end

  // Registered fetch port; fetch_data holds when nothing is served
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_data  <= '0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (fetch_req && !stall) begin
      fetch_valid <= 1'b1;
      if (w_fetch_in_range) begin
        fetch_data  <= r_mem[fetch_addr[IDX_W-1:0]];
        fetch_fault <= 1'b0;
      end else begin
        fetch_data  <= NOP_WORD;
        fetch_fault <= 1'b1;
      end
    end else begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
module tb_instruction_memory_loader;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;
  localparam logic [DW-1:0] NOP = 16'hF00D;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic [AW-1:0] ld_count;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          ld_busy;
  logic          ld_done;
  logic          ld_overflow;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_data;
  logic          fetch_valid;
  logic          fetch_fault;
  logic          stall;

  instruction_memory_loader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MEM_DEPTH (DEPTH),
    .NOP_WORD  (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_start   (ld_start),
    .ld_base    (ld_base),
    .ld_count   (ld_count),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_busy    (ld_busy),
    .ld_done    (ld_done),
    .ld_overflow(ld_overflow),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .fetch_valid(fetch_valid),
    .fetch_fault(fetch_fault),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  // Reference model: word-addressed store plus knowledge of which words
  // have ever been written (memory is not cleared by reset).
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  bit            m_ovf;
  logic [DW-1:0] m_last;
  bit            m_last_known;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One load transaction. gap_mode: 0 valid always, 1 alternating, 2 random.
  // noise drives ld_start and fetch_req while loading; both must be ignored.
  task automatic do_load(input int base, input int cnt, input int gap_mode, input bit noise);
    int k;
    int cyc;
    bit v;
    bit fr;
    logic [DW-1:0] dval;
    ld_start = 1'b1;
    ld_base  = AW'(base);
    ld_count = AW'(cnt);
    ld_valid = 1'b0;
    tick();
    ld_start = 1'b0;
    m_ovf = 1'b0;
    $display("load base=%h count=%0d mode=%0d", base, cnt, gap_mode);
    if (cnt == 0) begin
      chk("zero_done", ld_done, 1);
      chk("zero_stall", stall, 0);
      chk("zero_ovf", ld_overflow, 0);
      tick();
      chk("zero_done_clr", ld_done, 0);
      return;
    end
    chk("entry_busy", ld_busy, 1);
    chk("entry_ready", ld_ready, 1);
    chk("entry_stall", stall, 1);
    chk("entry_ovf_clr", ld_overflow, 0);
    k = 0;
    cyc = 0;
    while (k < cnt && cyc < 500) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      ld_valid = v;
      ld_data  = DW'($urandom);
      if (noise) begin
        ld_start   = 1'($urandom_range(0, 1));
        ld_base    = AW'($urandom);
        ld_count   = AW'($urandom);
        fetch_req  = 1'($urandom_range(0, 1));
        fetch_addr = AW'($urandom_range(0, DEPTH - 1));
      end
      fr   = fetch_req;
      dval = ld_data;
      tick();
      ld_valid  = 1'b0;
      ld_start  = 1'b0;
      fetch_req = 1'b0;
      if (v) begin
        if (base + k < DEPTH) begin
          m_mem[base + k]   = dval;
          m_known[base + k] = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
        k++;
      end
      cyc++;
      chk(fr ? "ld_fetch_blocked" : "ld_fetch_idle", fetch_valid, 0);
      chk("ld_ovf", ld_overflow, m_ovf);
      if (k < cnt) begin
        chk("ld_busy", ld_busy, 1);
        chk("ld_ready", ld_ready, 1);
        chk("ld_stall", stall, 1);
        chk("ld_done_early", ld_done, 0);
      end else begin
        chk("ld_done", ld_done, 1);
        chk("ld_busy_end", ld_busy, 0);
        chk("ld_stall_end", stall, 0);
      end
    end
    if (k < cnt) chk("ld_budget", k, cnt);
    tick();
    chk("ld_done_clr", ld_done, 0);
    chk("ld_ovf_sticky", ld_overflow, m_ovf);
  endtask

  // Back-to-back fetches, one per cycle, then one idle cycle.
  task automatic fetch_burst(input int n, input bit rnd, input int a0);
    int addr;
    for (int i = 0; i < n; i++) begin
      addr = rnd ? int'($urandom_range(0, 2 * DEPTH - 1)) : a0 + i;
      fetch_req  = 1'b1;
      fetch_addr = AW'(addr);
      tick();
      $display("fetch addr=%h data=%h valid=%0b fault=%0b", addr, fetch_data, fetch_valid, fetch_fault);
      chk("f_valid", fetch_valid, 1);
      if (addr < DEPTH) begin
        chk("f_fault0", fetch_fault, 0);
        if (m_known[addr]) chk("f_data", fetch_data, m_mem[addr]);
        m_last       = m_mem[addr];
        m_last_known = m_known[addr];
      end else begin
        chk("f_fault1", fetch_fault, 1);
        chk("f_nop", fetch_data, NOP);
        m_last       = NOP;
        m_last_known = 1'b1;
      end
    end
    fetch_req = 1'b0;
    tick();
    chk("f_idle_valid", fetch_valid, 0);
    chk("f_idle_fault", fetch_fault, 0);
    if (m_last_known) chk("f_hold", fetch_data, m_last);
  endtask

  initial begin
    int base;
    int cnt;
    logic [DW-1:0] d;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    rst = 1'b1; ld_start = 1'b0; ld_base = '0; ld_count = '0;
    ld_valid = 1'b0; ld_data = '0; fetch_req = 1'b0; fetch_addr = '0;
    m_ovf = 1'b0; m_last = '0; m_last_known = 1'b0;
    tick();
    tick();
    chk("rst_ready", ld_ready, 0);
    chk("rst_busy", ld_busy, 0);
    chk("rst_done", ld_done, 0);
    chk("rst_ovf", ld_overflow, 0);
    chk("rst_fvalid", fetch_valid, 0);
    chk("rst_ffault", fetch_fault, 0);
    chk("rst_fdata", fetch_data, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    tick();

    // Basic load with known values 0xA001..0xA004
    ld_start = 1'b1; ld_base = 16'h0010; ld_count = 16'd4; tick(); ld_start = 1'b0;
    chk("basic_busy", ld_busy, 1);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_data  = DW'(16'hA001 + i);
      tick();
      m_mem[16'h10 + i] = DW'(16'hA001 + i);
      m_known[16'h10 + i] = 1'b1;
      chk("basic_done_timing", ld_done, (i == 3) ? 1 : 0);
    end
    ld_valid = 1'b0;
    tick();
    fetch_burst(4, 1'b0, 16'h0010);

    // Backpressure gaps and fetch attempts during load
    do_load(16'h0040, 3, 1, 1'b0);
    fetch_req = 1'b1; fetch_addr = 16'h0040;
    ld_start = 1'b1; ld_base = 16'h0050; ld_count = 16'd2; tick();
    ld_start = 1'b0; fetch_req = 1'b0;
    chk("bp_fetch_pre_load", fetch_valid, 1);
    ld_valid = 1'b0; fetch_req = 1'b1; tick(); fetch_req = 1'b0;
    chk("bp_fetch_in_load", fetch_valid, 0);
    chk("bp_stall_gap", stall, 1);
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = DW'(16'hB000 + i); tick();
      m_mem[16'h50 + i] = DW'(16'hB000 + i); m_known[16'h50 + i] = 1'b1;
    end
    ld_valid = 1'b0;
    chk("bp_done", ld_done, 1);
    tick();
    fetch_burst(3, 1'b0, 16'h0040);
    fetch_burst(2, 1'b0, 16'h0050);

    // Overflow at the top of memory; ram[0], ram[1] must survive
    do_load(16'h0000, 2, 2, 1'b0);
    do_load(16'h03FE, 4, 0, 1'b0);
    chk("ovf_set", ld_overflow, 1);
    tick();
    tick();
    chk("ovf_sticky_idle", ld_overflow, 1);
    fetch_burst(2, 1'b0, 16'h03FE);
    fetch_burst(2, 1'b0, 16'h0000);
    fetch_burst(1, 1'b0, 16'h0400);
    fetch_burst(1, 1'b0, 16'hFFFF);

    // Zero count clears overflow and writes nothing
    do_load(16'h0000, 0, 0, 1'b0);
    fetch_burst(2, 1'b0, 16'h0000);

    // Reset mid-load: 2 of 5 beats land, third beat is dropped by reset
    do_load(16'h0100, 5, 0, 1'b0);
    ld_start = 1'b1; ld_base = 16'h0100; ld_count = 16'd5; tick(); ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d = DW'($urandom);
      ld_valid = 1'b1; ld_data = d; tick();
      m_mem[16'h100 + i] = d;
    end
    ld_valid = 1'b1; ld_data = ~m_mem[16'h102]; rst = 1'b1;
    tick();
    rst = 1'b0; ld_valid = 1'b0;
    m_ovf = 1'b0;
    $display("reset mid-load");
    chk("mrst_busy", ld_busy, 0);
    chk("mrst_stall", stall, 0);
    chk("mrst_ready", ld_ready, 0);
    chk("mrst_done", ld_done, 0);
    chk("mrst_ovf", ld_overflow, 0);
    chk("mrst_fvalid", fetch_valid, 0);
    chk("mrst_fdata", fetch_data, 0);
    tick();
    chk("mrst_idle_busy", ld_busy, 0);
    fetch_burst(5, 1'b0, 16'h0100);

    // Randomized loads with noise, checked against the model
    for (int t = 0; t < 12; t++) begin
      base = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DEPTH - 6, DEPTH + 4))
                                         : int'($urandom_range(0, DEPTH - 1));
      cnt  = int'($urandom_range(0, 8));
      do_load(base, cnt, 2, 1'b1);
      fetch_burst(cnt, 1'b0, base);
      fetch_burst(4, 1'b1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
